// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader
//   Drains length-prefixed frames from a byte FIFO. Each frame is a 16-bit
//   big-endian length L followed by L payload bytes. The payload goes out as
//   a valid/ready/last byte stream. The block also counts delivered frames
//   and flags oversize length headers.
//
// Ports
//   rclk      : clock
//   rst       : asynchronous active-high reset (shared with the FIFO)
//   ren       : FIFO read enable (a read is accepted when ren & ~rempty)
//   rdat      : FIFO read data, valid one cycle after an accepted read
//   rempty    : FIFO empty flag
//   m_valid   : output byte valid
//   m_data    : output payload byte
//   m_last    : final payload byte of a frame
//   m_ready   : downstream accepts on m_valid & m_ready
//   busy      : frame in progress, read in flight or output buffered
//   frame_cnt : frames fully delivered (wraps)
//   err_len   : sticky flag, set by a length header above MAX_LEN
//   clr_err   : synchronous clear of err_len (a same-cycle set wins)
module fifo_frame_reader #(
    parameter int WD      = 8,
    parameter int MAX_LEN = 1518,
    parameter int CW      = 16
) (
    input  logic          rclk,
    input  logic          rst,
    output logic          ren,
    input  logic [WD-1:0] rdat,
    input  logic          rempty,
    output logic          m_valid,
    output logic [WD-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic [CW-1:0] frame_cnt,
    output logic          err_len,
    input  logic          clr_err
);

    typedef enum logic [1:0] {
        HDR_HI  = 2'd0,
        HDR_LO  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t          r_state;
    logic [WD-1:0]   r_len_hi;
    logic [15:0]     r_remain;
    logic            r_rd_pend;
    logic [1:0]      r_occ;
    logic [WD-1:0]   r_buf_data [0:1];
    logic            r_buf_last [0:1];
    logic [CW-1:0]   r_frame_cnt;
    logic            r_err_len;

    logic            w_pop;
    logic            w_push;
    logic            w_push_last;
    logic [2:0]      w_credit_used;
    logic            w_ren;
    logic [15:0]     w_len;
    logic            w_err_set;
    logic [1:0]      w_wr_idx;

    assign w_pop = (r_occ != 2'd0) & m_ready;

    // Slots committed after this cycle: buffered bytes plus the byte in
    // flight, minus the one leaving now. A new read is only issued while a
    // slot is guaranteed, so the 2-entry buffer cannot overflow.
    assign w_credit_used = {1'b0, r_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_ren         = ~rst & ~rempty & (w_credit_used < 3'd2);

    assign w_len       = {r_len_hi, rdat};
    assign w_push      = r_rd_pend & (r_state == PAYLOAD);
    assign w_push_last = (r_remain == 16'd1);
    assign w_err_set   = r_rd_pend & (r_state == HDR_LO) & (w_len > 16'(MAX_LEN));

    // A same-cycle pop shifts the buffer down, so the push lands one lower.
    assign w_wr_idx = r_occ - {1'b0, w_pop};

    // Parser: advances only on an arriving byte, so an empty FIFO simply
    // stalls it in place.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state  <= HDR_HI;
            r_len_hi <= '0;
            r_remain <= '0;
        end else if (r_rd_pend) begin
            case (r_state)
                HDR_HI: begin
                    r_len_hi <= rdat;
                    r_state  <= HDR_LO;
                end
                HDR_LO: begin
                    if (w_len == 16'd0) begin
                        r_state <= HDR_HI;
                    end else begin
                        r_remain <= w_len;
                        r_state  <= (w_len > 16'(MAX_LEN)) ? DROP : PAYLOAD;
                    end
                end
                PAYLOAD, DROP: begin
                    r_remain <= r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        r_state <= HDR_HI;
                    end
                end
                default: r_state <= HDR_HI;
            endcase
        end
    end

    // Read tracking: rdat carries a byte exactly one cycle after a read.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_ren;
        end
    end

    // Two-entry output buffer, head always at index 0.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_occ         <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last[0] <= 1'b0;
            r_buf_last[1] <= 1'b0;
        end else begin
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_last[0] <= r_buf_last[1];
            end
            // Placed after the shift so a push into slot 0 wins over it.
            if (w_push) begin
                r_buf_data[w_wr_idx[0]] <= rdat;
                r_buf_last[w_wr_idx[0]] <= w_push_last;
            end
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_pop & r_buf_last[0]) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_err_len <= 1'b0;
        end else if (w_err_set) begin
            r_err_len <= 1'b1;
        end else if (clr_err) begin
            r_err_len <= 1'b0;
        end
    end

    assign ren       = w_ren;
    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf_data[0];
    assign m_last    = r_buf_last[0];
    assign busy      = (r_state != HDR_HI) | r_rd_pend | (r_occ != 2'd0);
    assign frame_cnt = r_frame_cnt;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader: a behavioural byte FIFO feeds the DUT,
// expected output bytes are queued as frames are written and compared as
// the DUT delivers them.
module tb_fifo_frame_reader;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        ren;
    logic [7:0]  rdat;
    logic        rempty;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        err_len;
    logic        clr_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] fifo_mem [0:4095];
    int wp = 0;
    int rp = 0;

    logic [8:0] exp_q [$];
    int         pop_cyc [$];

    always #5 rclk = ~rclk;

    fifo_frame_reader #(.WD(8), .MAX_LEN(1518), .CW(16)) dut (
        .rclk      (rclk),
        .rst       (rst),
        .ren       (ren),
        .rdat      (rdat),
        .rempty    (rempty),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_len   (err_len),
        .clr_err   (clr_err)
    );

    // Behavioural FIFO read port: data appears the cycle after acceptance.
    assign rempty = (wp == rp);
    always @(posedge rclk or posedge rst) begin
        if (rst) begin
            rp   <= wp;
            rdat <= 8'h00;
        end else if (ren && !rempty) begin
            rdat <= fifo_mem[rp & 4095];
            rp   <= rp + 1;
        end
    end

    always @(posedge rclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard; a transfer happens at the next rising edge.
    always @(negedge rclk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {23'd0, m_last, m_data}, 32'h1ff);
                chk("spurious_sb", exp_q.size(), 1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                $display("[TB] out data=%02h last=%0d cyc=%0d", m_data, m_last, cyc);
                chk("out_byte", {23'd0, m_last, m_data}, {23'd0, e});
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic put(input logic [7:0] b);
        fifo_mem[wp & 4095] = b;
        wp = wp + 1;
    endtask

    task automatic put_exp(input logic [7:0] b, input logic last);
        put(b);
        exp_q.push_back({last, b});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        @(negedge rclk);
        while ((exp_q.size() != 0 || busy || !rempty) && n < max_cyc) begin
            @(negedge rclk);
            n++;
        end
        chk("drained_busy", {31'd0, busy}, 0);
        chk("drained_sb", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        // Reset state
        tick(3);
        chk("rst_ren", {31'd0, ren}, 0);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_data", {24'd0, m_data}, 0);
        chk("rst_last", {31'd0, m_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cnt", {16'd0, frame_cnt}, 0);
        chk("rst_err", {31'd0, err_len}, 0);
        rst = 1'b0;
        tick(2);

        // Single frame, consecutive output
        pop_cyc.delete();
        put(8'h00); put(8'h03);
        put_exp(8'hAA, 1'b0); put_exp(8'hBB, 1'b0); put_exp(8'hCC, 1'b1);
        wait_drain(100);
        chk("single_cnt", {16'd0, frame_cnt}, 1);
        if (pop_cyc.size() == 3) begin
            chk("single_gap0", pop_cyc[1] - pop_cyc[0], 1);
            chk("single_gap1", pop_cyc[2] - pop_cyc[1], 1);
        end else chk("single_npop", pop_cyc.size(), 3);

        // Backpressure
        put(8'h00); put(8'h03);
        put_exp(8'hAA, 1'b0); put_exp(8'hBB, 1'b0); put_exp(8'hCC, 1'b1);
        for (int i = 0; i < 20; i++) begin
            m_ready = (i % 3 == 0);
            tick(1);
        end
        m_ready = 1'b1;
        wait_drain(100);
        chk("bp_cnt", {16'd0, frame_cnt}, 2);

        // Zero length, oversize length, then a 1-byte frame
        put(8'h00); put(8'h00);
        put(8'h06); put(8'h00);
        for (int i = 0; i < 1536; i++) put(8'(i));
        put(8'h00); put(8'h01); put_exp(8'h5A, 1'b1);
        tick(12);
        chk("err_after_hdr", {31'd0, err_len}, 1);
        chk("drop_busy", {31'd0, busy}, 1);
        wait_drain(5000);
        chk("over_cnt", {16'd0, frame_cnt}, 3);
        chk("err_sticky", {31'd0, err_len}, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("err_clr", {31'd0, err_len}, 0);

        // Back-to-back frames
        pop_cyc.delete();
        put(8'h00); put(8'h02); put_exp(8'h11, 1'b0); put_exp(8'h22, 1'b1);
        put(8'h00); put(8'h01); put_exp(8'h33, 1'b1);
        wait_drain(100);
        chk("b2b_cnt", {16'd0, frame_cnt}, 5);
        if (pop_cyc.size() == 3) begin
            chk("b2b_gap0", pop_cyc[1] - pop_cyc[0], 1);
            chk("b2b_gap1", pop_cyc[2] - pop_cyc[1], 3);
        end else chk("b2b_npop", pop_cyc.size(), 3);

        // Starved FIFO
        pop_cyc.delete();
        put(8'h00); put(8'h04);
        for (int i = 0; i < 4; i++) begin
            tick(5);
            chk("starved_busy", {31'd0, busy}, 1);
            put_exp(8'hC0 + 8'(i), (i == 3));
        end
        wait_drain(100);
        chk("starved_cnt", {16'd0, frame_cnt}, 6);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("starved_gap", pop_cyc[i] - pop_cyc[i-1], 5);
        end else chk("starved_npop", pop_cyc.size(), 4);

        // Reset mid-frame after 2 of 4 payload bytes
        put(8'h00); put(8'h04); put_exp(8'hD0, 1'b0); put_exp(8'hD1, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge rclk);
            n++;
        end
        chk("mid_sb", exp_q.size(), 0);
        tick(2);
        chk("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("arst_ren", {31'd0, ren}, 0);
        chk("arst_valid", {31'd0, m_valid}, 0);
        chk("arst_data", {24'd0, m_data}, 0);
        chk("arst_last", {31'd0, m_last}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_cnt", {16'd0, frame_cnt}, 0);
        chk("arst_err", {31'd0, err_len}, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        put(8'h00); put(8'h01); put_exp(8'h77, 1'b1);
        wait_drain(100);
        chk("post_rst_cnt", {16'd0, frame_cnt}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Single-clock read-side controller for the switch's byte FIFO. It drains length-prefixed frames from the FIFO read port and presents each payload as a byte stream with valid/ready/last handshake toward the egress logic. It sits in the `rclk` domain, directly on the FIFO's `ren`/`rdat`/`rempty` port. It also counts delivered frames and flags illegal length headers.

## Interface
Parameters:
- `WD`, 8, FIFO data width; fixed at 8, since headers are parsed bytewise.
- `MAX_LEN`, 1518, largest legal payload length in bytes.
- `CW`, 16, width of `frame_cnt`.

Ports:
- `rclk`  in  1  the single clock for the block.
- `rst`  in  1  reset; asynchronous, active-high; shared with the FIFO.
- `ren`  out  1  FIFO read enable.
- `rdat`  in  WD  FIFO read data; valid one cycle after a read is accepted.
- `rempty`  in  1  FIFO empty flag.
- `m_valid`  out  1  output byte valid.
- `m_data`  out  WD  output payload byte.
- `m_last`  out  1  marks the final payload byte of a frame.
- `m_ready`  in  1  downstream accepts the byte on `m_valid & m_ready`.
- `busy`  out  1  frame in progress, or data in flight or buffered.
- `frame_cnt`  out  CW  count of frames fully delivered; wraps modulo 2^CW.
- `err_len`  out  1  sticky flag for an illegal length header.
- `clr_err`  in  1  synchronous clear of `err_len`.

## Operation
- **FIFO frame format:** a 16-bit big-endian length L (high byte first), then exactly L payload bytes, then the next header.
- **Reads:**
  - A read is accepted at edge N when `ren=1` and `rempty=0`.
  - That byte is sampled from `rdat` at edge N+1.
  - `rd_pend` is a 1-bit register that tracks the single byte in flight.
- **Output buffer:** a 2-entry FIFO `obuf` holds {data, last}; `occ` is its count (0..2). `pop = m_valid & m_ready`.
- **Read enable rule:** `ren = ~rempty & ((occ + rd_pend - pop) < 2)`. This is a credit scheme, so `obuf` can never overflow.
- **Parser:** consumes each arriving byte in order. State machine:
  - HDR_HI (reset state): latch byte into L[15:8]; go to HDR_LO.
  - HDR_LO: latch L[7:0] and compute the full L.
    - L=0: go to HDR_HI; no output, no count.
    - L>MAX_LEN: set `err_len`, load `remain=L`, go to DROP.
    - Otherwise load `remain=L`, go to PAYLOAD.
  - PAYLOAD: push {byte, remain==1} into `obuf` and decrement `remain`. When remain==1, go to HDR_HI.
  - DROP: discard the byte and decrement `remain`. When remain==1, go to HDR_HI.
- **Counters and flags:**
  - `remain` is 16 bits.
  - `frame_cnt` increments on `pop & m_last`; frames dropped for length are not counted.
  - `err_len`: set has priority over `clr_err` when both occur in the same cycle.
- **Status and output:**
  - `busy = (state!=HDR_HI) | rd_pend | (occ!=0)`.
  - `m_valid = (occ!=0)`; `m_data` and `m_last` come from the head of `obuf`.

## Timing
- **Reset values:** `ren` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0, `frame_cnt` 0, `err_len` 0. State HDR_HI, `occ` 0, `rd_pend` 0, `remain` 0.
- **Latency:** a first payload byte read at edge N appears on `m_valid` after edge N+1.
- **Throughput:** one byte per cycle when the FIFO is non-empty and `m_ready` is held high.
- **Header overhead:** two read cycles per frame, during which there is no output.
- **Backpressure:** while `m_valid & ~m_ready`, `m_data` and `m_last` hold stable. `ren` deasserts once credit reaches 0 and resumes in the same cycle `pop` frees space.
- **Simultaneous push and pop** in one cycle: `occ` is unchanged, and the data order is preserved.
- **Frame boundary:** the next frame's header bytes may be read while the last payload bytes still sit in `obuf`. This is required, so that back-to-back frames have no bubble beyond the 2 header cycles.
- **FIFO empty mid-frame:** the parser waits in its current state; output pauses with no error.
- **Reset mid-frame:** everything above returns to reset values immediately. The partial frame is abandoned, and the FIFO is reset by the same `rst`.

## Test plan
- **Single frame:** FIFO holds 00 03 AA BB CC, `m_ready=1` → `m_data` AA, BB, CC on consecutive cycles. `m_last` is high only on CC. `frame_cnt` goes 0→1, then `busy` returns to 0.
- **Backpressure:** same frame with `m_ready` toggling 1,0,0,1,... → each byte is held until accepted, nothing is lost or duplicated, and `ren` never lets `occ` exceed 2.
- **Zero and oversize lengths:** FIFO holds 00 00, then 06 00 (L=1536) plus 1536 bytes, then 00 01 5A →
  - no output for the first two frames;
  - `err_len=1` after the second header;
  - a single byte 5A with `m_last=1`;
  - `frame_cnt=1`.
  - Then pulse `clr_err` → `err_len=0`.
- **Back-to-back frames:** 00 02 11 22 00 01 33 preloaded, `m_ready=1` → output 11, 22(last), 33(last) with exactly 2 idle cycles between 22 and 33; `frame_cnt=2`.
- **Starved FIFO:** header 00 04 written, then payload bytes written one every 5 cycles → output bytes spaced accordingly, `m_last` only on the 4th byte, `busy` high throughout.
- **Reset mid-frame:** assert `rst` after 2 of 4 payload bytes → all outputs return to reset values asynchronously. A new frame 00 01 77 after release is delivered correctly.
